// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up and valid/ready handshakes.
module alu_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic                rneg_q, rneg_d;

    // Operand decode on the live inputs, used only on the accept cycle
    logic            s1_signed, s2_signed, s1_neg, s2_neg;
    logic            div_zero, div_ovf, is_div;
    logic [XLEN-1:0] mag1, mag2, special_res;

    always_comb begin
        s1_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        s2_signed = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        s1_neg    = s1_signed && src1[XLEN-1];
        s2_neg    = s2_signed && src2[XLEN-1];
        mag1      = s1_neg ? -src1 : src1;
        mag2      = s2_neg ? -src2 : src2;
        is_div    = op[2];
        div_zero  = (src2 == '0);
        div_ovf   = ((op == 3'd4) || (op == 3'd6)) && (src1 == MIN_VAL) && (src2 == '1);
        if (div_zero) begin
            special_res = op[1] ? src1 : '1;
        end else begin
            special_res = op[1] ? '0 : src1;
        end
    end

    // One iteration step for each datapath; acc holds {hi, lo}
    logic [XLEN-1:0]   acc_hi, acc_lo;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     r_shift;
    logic              r_ge;
    logic [XLEN-1:0]   r_diff, r_new;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        acc_hi   = acc_q[2*XLEN-1:XLEN];
        acc_lo   = acc_q[XLEN-1:0];
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_lo[XLEN-1:1]};
        r_shift  = {acc_hi, acc_lo[XLEN-1]};
        r_ge     = (r_shift >= {1'b0, b_q});
        r_diff   = r_shift[XLEN-1:0] - b_q;
        r_new    = r_ge ? r_diff : r_shift[XLEN-1:0];
        div_next = {r_new, acc_lo[XLEN-2:0], r_ge};
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_lo : acc_lo;
        rem_fix  = rneg_q ? -acc_hi : acc_hi;
        case (op_q)
            3'd0:          fix_res = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          fix_res = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:    fix_res = quo_fix;
            default:       fix_res = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_d   = op;
                        a_d    = mag1;
                        b_d    = mag2;
                        neg_d  = s1_neg ^ s2_neg;
                        rneg_d = s1_neg;
                        cnt_d  = CNT_W'(XLEN);
                        if (is_div && (div_zero || div_ovf)) begin
                            result_d = special_res;
                            state_d  = S_DONE;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
                            state_d = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    result_d = fix_res;
                    state_d  = S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed RV32M cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_alu_muldiv;

    localparam int XLEN = 32;
    localparam logic [31:0] MIN_VAL = 32'h8000_0000;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] last_result = '0;

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: RV32M semantics straight from signed/unsigned 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MIN_VAL && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MIN_VAL && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o < 3'd4) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return ((o == 3'd4) || (o == 3'd6)) && (a == MIN_VAL) && (b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return MIN_VAL;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_res;
        logic [31:0] held;
        int          exp_lat;
        int          lat;
        bit          ir_bad;
        exp_res = ref_model(o, a, b);
        exp_lat = is_special(o, a, b) ? 1 : XLEN + 2;
        @(negedge clk);
        out_ready = (hold == 0);
        op        = o;
        src1      = a;
        src2      = b;
        in_valid  = 1'b1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op       = 3'($urandom);
        src1     = $urandom;
        src2     = $urandom;
        lat      = 1;
        ir_bad   = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ir_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        if (in_ready) ir_bad = 1'b1;
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", result, exp_res);
        check("in_ready_low", 32'(ir_bad), 32'd0);
        if (hold > 0) begin
            held = result;
            repeat (hold) begin
                @(negedge clk);
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_result", result, held);
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        last_result = exp_res;
        $display("[TB] op=%0d src1=%h src2=%h result=%h expected=%h latency=%0d hold=%0d",
                 o, a, b, result, exp_res, lat, hold);
    endtask

    logic [2:0]  dir_op  [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
    logic [31:0] dir_a   [14] = '{32'd7, MIN_VAL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                  32'd5, 32'd5, MIN_VAL, MIN_VAL, 32'd0, 32'h7FFF_FFFF};
    logic [31:0] dir_b   [14] = '{32'hFFFF_FFFD, MIN_VAL, 32'hFFFF_FFFF, 32'd2,
                                  32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] dir_exp [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'hFFFF_FFFF, 32'd5, MIN_VAL, 32'd0, 32'hFFFF_FFFF, 32'd0};

    int seen_valid;

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        src1      = '0;
        src2      = '0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Hand-computed values anchor the reference model itself
        for (int i = 0; i < 14; i++) begin
            check("model_table", ref_model(dir_op[i], dir_a[i], dir_b[i]), dir_exp[i]);
            run_op(dir_op[i], dir_a[i], dir_b[i], 0);
        end

        run_op(3'd0, 32'd12345, 32'hFFFF_0000, 5);
        run_op(3'd5, 32'd77, 32'd5, 0);

        // Flush in the middle of CALC, with a competing in_valid that must be ignored
        @(negedge clk);
        op = 3'd0; src1 = 32'd99; src2 = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 3'd5; src1 = 32'd9; src2 = 32'd3;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_result_held", result, last_result);
        seen_valid = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        check("flush_no_valid", 32'(seen_valid), 32'd0);
        $display("[TB] flush mid-CALC result=%h held=%h", result, last_result);

        // Asynchronous reset while a result waits in DONE
        @(negedge clk);
        out_ready = 1'b0; op = 3'd4; src1 = 32'd5; src2 = 32'd0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        check("pre_reset_result", result, 32'hFFFF_FFFF);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_result", result, 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        $display("[TB] async reset in DONE out_valid=%0d result=%h", out_valid, result);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        last_result = '0;
        run_op(3'd5, 32'd9, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            int          rh;
            ro = 3'($urandom_range(0, 7));
            ra = pick_operand();
            rb = pick_operand();
            rh = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            run_op(ro, ra, rb, rh);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the RV32M extension; it sits beside the single-cycle integer ALU in the EX stage.
- Takes over operations the combinational ALU cannot complete in one cycle: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Handshakes with the pipeline using valid/ready on both input and output. Supports flush on branch mispredict or trap.

Parameters:
XLEN  32  operand and result width in bits; must be ≥ 4 and even
CNT_W  $clog2(XLEN)+1  iteration counter width (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  abort any operation in progress; highest priority after reset
in_valid  input  1  op/src1/src2 valid
in_ready  output  1  unit can accept a new operation
op  input  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
src1  input  XLEN  rs1 operand (multiplicand / dividend)
src2  input  XLEN  rs2 operand (multiplier / divisor)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
result  output  XLEN  operation result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - out_valid=0, result=0, busy=0, in_ready=1 while in IDLE.
  - All internal registers are cleared.
- FSM states and transitions:
  - IDLE: in_ready=1. Accept occurs when in_valid & in_ready. On accept, latch op and operands.
    - A special divide case goes to DONE.
    - Any other operation goes to CALC with counter = XLEN.
  - CALC: radix-2, one bit per cycle, XLEN cycles. Then go to FIX.
    - Multiply: shift-add on operand magnitudes into a 2·XLEN product register.
    - Divide: restoring divide on magnitudes into quotient and remainder registers.
  - FIX: apply sign correction and select the high or low word. Register result, then go to DONE.
  - DONE: out_valid=1; result is held stable. When out_ready=1, go to IDLE.
- Latency:
  - Normal path: out_valid asserts XLEN+2 cycles after the accept edge (34 at XLEN=32).
  - Special path: out_valid asserts 1 cycle after the accept edge.
- Throughput: no back-to-back accept. in_ready is low from the accept edge until the cycle after the output handshake.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - *U variants: both operands unsigned.
  - Operate on magnitudes. Negate the product when operand signs differ.
  - Quotient sign = sign(src1) XOR sign(src2). Remainder sign = sign(src1). Quotient truncates toward zero.
- Result selection:
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2·XLEN-1:XLEN].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special divide cases (no iteration):
  - Divide by zero: DIV/DIVU return all ones; REM/REMU return src1.
  - Signed overflow (src1 = most negative value, src2 = all ones, DIV/REM only): DIV returns src1; REM returns 0.
  - DIVU/REMU never overflow.
- flush:
  - When sampled high, state goes to IDLE on the next edge and out_valid drops to 0.
  - The in-progress result is discarded; result holds its previous register value.
  - in_valid in the same cycle as flush is not accepted.
- Asynchronous reset during CALC or DONE: out_valid drops immediately (no clock edge needed).
- Output hold: out_valid must not deassert without an out_ready handshake, flush or reset.
- Inputs after accept: op/src1/src2 may change freely; they have no effect until the next accept.

Test Plan:
- MUL src1=7, src2=0xFFFFFFFD (-3), out_ready=1 → out_valid exactly 34 cycles after accept, result=0xFFFFFFEB; in_ready=0 throughout.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7)/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- Special cases: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0. Each gives out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid=1 and result stable, in_ready=0; raise out_ready → IDLE next cycle, then a new accept succeeds.
- Flush at cycle 10 of CALC → IDLE next edge, out_valid never asserts. Then pull rst_n low mid-DONE → out_valid=0 and result=0 immediately; after reset, DIVU 9/3 → 3.
